// File: rtl/matrix_pkg.sv
// Shared constants and state encoding for the dot-matrix / beeper arbiter.
package matrix_pkg;

  localparam logic [7:0] HANG_OFF    = 8'hFF;
  localparam logic [7:0] RED_OFF     = 8'h00;
  localparam int         MATRIX_ROWS = 8;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    DRAIN,
    BLANK
  } state_t;

endpackage

// File: rtl/fixed_prio_pick.sv
// Lowest-set-bit picker over (vec & mask); returns the one-hot winner and its index.
module fixed_prio_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    // Scan downwards so the last hit, i.e. the lowest index, wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i] && mask[i]) begin
        onehot = N'(1) << i;
        idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/matrix_beep_arbiter.sv
// Fixed-priority owner arbitration for the shared 8x8 matrix and beeper, with
// frame-aligned handover, drain timeout and a blanking gap between owners.
module matrix_beep_arbiter
  import matrix_pkg::*;
#(
  parameter int NREQ          = 3,
  parameter int BLANK_CYCLES  = 2,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] hang_in,
  input  logic [NREQ*8-1:0] red_in,
  input  logic [NREQ-1:0]   beep_in,
  input  logic [NREQ-1:0]   frame_end_in,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        hang,
  output logic [7:0]        red,
  output logic              beep,
  output logic              busy
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (BLANK_CYCLES > DRAIN_TIMEOUT) ? BLANK_CYCLES : DRAIN_TIMEOUT;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  state_t          state, state_n;
  logic [IW-1:0]   owner, owner_n;
  logic [CW-1:0]   drain_cnt, drain_n;
  logic [CW-1:0]   blank_cnt, blank_n;
  logic            armed;

  logic [NREQ-1:0] pick_onehot, hi_onehot, hi_mask;
  logic [IW-1:0]   pick_idx, hi_idx_unused;
  logic            any_req, hi_pending, owner_req, owner_fe;

  assign hi_mask = (NREQ'(1) << owner) - NREQ'(1);

  fixed_prio_pick #(.N(NREQ), .IW(IW)) u_pick (
    .vec    (req),
    .mask   ({NREQ{1'b1}}),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  fixed_prio_pick #(.N(NREQ), .IW(IW)) u_hi_pick (
    .vec    (req),
    .mask   (hi_mask),
    .onehot (hi_onehot),
    .idx    (hi_idx_unused)
  );

  assign any_req    = |pick_onehot;
  assign hi_pending = |hi_onehot;
  assign owner_req  = req[owner];
  assign owner_fe   = frame_end_in[owner];

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_n = state;
    owner_n = owner;
    drain_n = drain_cnt;
    blank_n = blank_cnt;
    case (state)
      IDLE: begin
        if (armed && any_req) begin
          state_n = OWN;
          owner_n = pick_idx;
        end
      end
      OWN: begin
        if (!owner_req || (hi_pending && owner_fe)) begin
          state_n = BLANK;
          blank_n = '0;
        end else if (hi_pending) begin
          state_n = DRAIN;
          drain_n = '0;
        end
      end
      DRAIN: begin
        if (owner_fe || drain_cnt == DRAIN_LAST || !owner_req) begin
          state_n = BLANK;
          blank_n = '0;
        end else if (!hi_pending) begin
          state_n = OWN;
          drain_n = '0;
        end else if (drain_cnt != CNT_MAX) begin
          drain_n = drain_cnt + CW'(1);
        end
      end
      BLANK: begin
        if (blank_cnt == BLANK_LAST) begin
          blank_n = '0;
          if (any_req) begin
            state_n = OWN;
            owner_n = pick_idx;
          end else begin
            state_n = IDLE;
          end
        end else begin
          blank_n = blank_cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      drain_cnt <= '0;
      blank_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      drain_cnt <= drain_n;
      blank_cnt <= blank_n;
      armed     <= 1'b1;
    end
  end

  // Outputs are registered from the next state, so they line up with gnt and
  // carry the owner's inputs with exactly one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt  <= '0;
      hang <= HANG_OFF;
      red  <= RED_OFF;
      beep <= 1'b0;
    end else if (state_n == OWN || state_n == DRAIN) begin
      gnt  <= NREQ'(1) << owner_n;
      hang <= hang_in[int'(owner_n)*MATRIX_ROWS +: MATRIX_ROWS];
      red  <= red_in[int'(owner_n)*MATRIX_ROWS +: MATRIX_ROWS];
      beep <= beep_in[owner_n];
    end else begin
      gnt  <= '0;
      hang <= HANG_OFF;
      red  <= RED_OFF;
      beep <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_matrix_beep_arbiter.sv
// Directed scoreboard bench: the driver queues the expected next-cycle outputs,
// a negedge monitor pops and compares them.
module tb_matrix_beep_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, beep_in, frame_end_in;
  logic [23:0] hang_in, red_in;
  logic [2:0]  gnt;
  logic [7:0]  hang, red;
  logic        beep, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] hang_tab [3] = '{8'h7E, 8'hBD, 8'hDB};
  logic [7:0] red_tab  [3] = '{8'h11, 8'h22, 8'h44};

  typedef struct {
    int          cyc;
    logic [20:0] v;
  } exp_t;

  exp_t q[$];

  matrix_beep_arbiter #(.NREQ(3), .BLANK_CYCLES(2), .DRAIN_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .hang_in      (hang_in),
    .red_in       (red_in),
    .beep_in      (beep_in),
    .frame_end_in (frame_end_in),
    .gnt          (gnt),
    .hang         (hang),
    .red          (red),
    .beep         (beep),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected {gnt, hang, red, beep, busy} for a given grant and beep pattern.
  function automatic logic [20:0] mk(input logic [2:0] g, input logic [2:0] bp, input logic b);
    logic [7:0] h;
    logic [7:0] r;
    h = 8'hFF;
    r = 8'h00;
    for (int i = 0; i < 3; i++) begin
      if (g[i]) begin
        h = hang_tab[i];
        r = red_tab[i];
      end
    end
    return {g, h, r, |(g & bp), b};
  endfunction

  // Apply inputs for this cycle and queue the outputs expected after the edge.
  task automatic tick(input logic [2:0] r, input logic [2:0] fe, input logic [2:0] bp,
                      input logic [2:0] g, input logic b);
    exp_t e;
    req          = r;
    frame_end_in = fe;
    beep_in      = bp;
    e.cyc = cyc + 1;
    e.v   = mk(g, bp, b);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      check($sformatf("stale_cyc%0d", e.cyc), 32'(cyc), 32'(e.cyc));
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      check($sformatf("out_cyc%0d", cyc), 32'({gnt, hang, red, beep, busy}), 32'(e.v));
    end
  end

  initial begin
    hang_in      = {hang_tab[2], hang_tab[1], hang_tab[0]};
    red_in       = {red_tab[2], red_tab[1], red_tab[0]};
    rst_n        = 1'b0;
    req          = '0;
    beep_in      = '0;
    frame_end_in = '0;

    // 1: reset held with all requests, then first grant on the 2nd edge.
    repeat (3) tick(3'b111, 3'b000, 3'b101, 3'b000, 1'b0);
    rst_n = 1'b1;
    tick(3'b111, 3'b000, 3'b101, 3'b000, 1'b0);
    tick(3'b111, 3'b000, 3'b101, 3'b001, 1'b1);
    tick(3'b111, 3'b000, 3'b100, 3'b001, 1'b1);
    tick(3'b111, 3'b000, 3'b001, 3'b001, 1'b1);

    // Move ownership to requester 2.
    tick(3'b100, 3'b000, 3'b000, 3'b000, 1'b1);
    tick(3'b100, 3'b000, 3'b000, 3'b000, 1'b1);
    tick(3'b100, 3'b000, 3'b100, 3'b100, 1'b1);
    tick(3'b100, 3'b000, 3'b000, 3'b100, 1'b1);

    // 2: higher request mid-frame, owner frame_end 3 cycles later.
    tick(3'b101, 3'b000, 3'b100, 3'b100, 1'b1);
    tick(3'b101, 3'b011, 3'b000, 3'b100, 1'b1);
    tick(3'b101, 3'b000, 3'b100, 3'b100, 1'b1);
    tick(3'b101, 3'b100, 3'b000, 3'b000, 1'b1);
    tick(3'b101, 3'b000, 3'b000, 3'b000, 1'b1);
    tick(3'b101, 3'b000, 3'b000, 3'b001, 1'b1);

    // Move ownership to requester 1.
    tick(3'b010, 3'b000, 3'b000, 3'b000, 1'b1);
    tick(3'b010, 3'b000, 3'b000, 3'b000, 1'b1);
    tick(3'b010, 3'b000, 3'b010, 3'b010, 1'b1);
    tick(3'b010, 3'b000, 3'b000, 3'b010, 1'b1);

    // 3: no frame_end from owner 1 -> forced handover after 16 DRAIN cycles.
    tick(3'b011, 3'b000, 3'b000, 3'b010, 1'b1);
    repeat (15) tick(3'b011, 3'b000, 3'b010, 3'b010, 1'b1);
    tick(3'b011, 3'b000, 3'b000, 3'b000, 1'b1);
    tick(3'b011, 3'b000, 3'b000, 3'b000, 1'b1);
    tick(3'b011, 3'b000, 3'b001, 3'b001, 1'b1);

    // 4: lower-priority request never preempts owner 1.
    tick(3'b110, 3'b000, 3'b000, 3'b000, 1'b1);
    tick(3'b110, 3'b000, 3'b000, 3'b000, 1'b1);
    tick(3'b110, 3'b000, 3'b000, 3'b010, 1'b1);
    repeat (20) tick(3'b110, 3'b100, 3'b000, 3'b010, 1'b1);
    tick(3'b100, 3'b000, 3'b000, 3'b000, 1'b1);
    tick(3'b100, 3'b000, 3'b000, 3'b000, 1'b1);
    tick(3'b100, 3'b000, 3'b000, 3'b100, 1'b1);

    // 5: higher request withdrawn during DRAIN -> back to OWN, no blank.
    repeat (4) tick(3'b101, 3'b000, 3'b100, 3'b100, 1'b1);
    tick(3'b100, 3'b000, 3'b000, 3'b100, 1'b1);
    tick(3'b100, 3'b000, 3'b100, 3'b100, 1'b1);

    // 6: direct OWN->BLANK on frame_end, owner 0 beeping, then all requests drop.
    tick(3'b101, 3'b100, 3'b000, 3'b000, 1'b1);
    tick(3'b101, 3'b000, 3'b000, 3'b000, 1'b1);
    tick(3'b101, 3'b000, 3'b001, 3'b001, 1'b1);
    tick(3'b001, 3'b000, 3'b110, 3'b001, 1'b1);
    tick(3'b001, 3'b000, 3'b001, 3'b001, 1'b1);
    tick(3'b001, 3'b000, 3'b110, 3'b001, 1'b1);
    tick(3'b000, 3'b000, 3'b111, 3'b000, 1'b1);
    tick(3'b000, 3'b000, 3'b111, 3'b000, 1'b1);
    tick(3'b000, 3'b000, 3'b111, 3'b000, 1'b0);
    tick(3'b000, 3'b000, 3'b111, 3'b000, 1'b0);

    // Regrant from IDLE, then async reset mid-ownership blanks at once.
    tick(3'b001, 3'b000, 3'b001, 3'b001, 1'b1);
    @(negedge clk);
    #1;
    check("queue_drain", 32'(q.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'({gnt, hang, red, beep, busy}), 32'(mk(3'b000, 3'b000, 1'b0)));
    #10;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
